uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/endeavour_uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 82 ++++++++
 rtl/uart_receiver.sv | 181 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/endeavour_uart_pkg.sv
// Shared definitions for the UART receive path: receiver states, data width
// and the smallest divisor the bit timer can work with.
package endeavour_uart_pkg;

    localparam int DATA_W = 8;
    localparam logic [15:0] MIN_DIVISOR = 16'd4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Divisors below the minimum leave no room for a half-bit start check,
    // so they are raised to the minimum.
    function automatic logic [15:0] clamp_divisor(input logic [15:0] div);
        return (div < MIN_DIVISOR) ? MIN_DIVISOR : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO with registered head-of-queue outputs.
// A push while full is ignored unless a pop happens in the same cycle.
module uart_rx_fifo
    import endeavour_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Next storage, pointer and occupancy state; the head is read from the
    // post-update storage so a push into an empty queue is forwarded directly.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        rd_valid_d = (count_d != '0);
        rd_data_d  = rd_data_q;
        if (count_d != '0) begin
            rd_data_d = mem_d[rd_ptr_d];
        end
    end

    // Register the queue state and the head outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes the serial line, times each bit from a
// runtime divisor latched at the start edge, and queues good bytes in a FIFO.
module uart_receiver
    import endeavour_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    input  logic [15:0]       divisor,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_error,
    output logic              overflow
);

    rx_state_e         state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              rx_prev_q, rx_prev_d;
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       div_q, div_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_error_q, frame_error_d;
    logic              overflow_q, overflow_d;

    logic              rx_s;
    logic              fall;
    logic              expire;
    logic [15:0]       clamped_div;
    logic              push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign rx_s        = sync2_q;
    assign expire      = (cnt_q == 16'd1);
    assign clamped_div = clamp_divisor(divisor);
    assign fall        = armed_q && rx_prev_q && !rx_s;
    assign fifo_pop    = rx_ready && !fifo_empty;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

    // Synchronizer and start-edge qualification. The synchronizer resets to
    // idle-high, so the line only arms edge detection once the real line has
    // been seen high after reset; a line held low through reset is ignored.
    always_comb begin
        sync1_d   = uart_rx;
        sync2_d   = sync1_q;
        rx_prev_d = sync2_q;
        settle_d  = (settle_q == 2'd2) ? 2'd2 : settle_q + 2'd1;
        armed_d   = armed_q || ((settle_q == 2'd2) && rx_s);
    end

    // Next-state and datapath: half-bit wait to the start midpoint, then one
    // full latched bit period per data and stop sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    div_d   = clamped_div;
                    cnt_d   = {1'b0, clamped_div[15:1]};
                    state_d = START;
                end
            end
            START: begin
                if (expire) begin
                    if (!rx_s) begin
                        cnt_d     = div_q;
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = div_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (expire) begin
                    cnt_d   = 16'd0;
                    state_d = rx_s ? IDLE : BREAK;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Stop-bit outcome: a high stop pushes the byte, a low stop flags a frame
    // error instead, so the two status pulses can never coincide.
    always_comb begin
        push          = 1'b0;
        frame_error_d = 1'b0;
        if ((state_q == STOP) && expire) begin
            push          = rx_s;
            frame_error_d = !rx_s;
        end
        overflow_d = push && fifo_full && !fifo_pop;
    end

    // State register for the receiver and its status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            settle_q      <= 2'd0;
            armed_q       <= 1'b0;
            cnt_q         <= 16'd0;
            div_q         <= 16'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_prev_q     <= rx_prev_d;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_q),
        .pop       (fifo_pop),
        .rd_data   (rx_data),
        .rd_valid  (rx_valid),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: serial frames are driven bit by bit and
// the received bytes and status pulses are compared with hand-worked values.
module tb_uart_receiver;

    localparam int FAST_BIT = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic [15:0] divisor;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_error;
    logic        overflow;

    int     errors = 0;
    int     checks = 0;
    int     ovf_count = 0;
    int     ferr_count = 0;
    int     ovf0;
    int     ferr0;
    longint start_time = 0;
    longint rise_time = 0;
    longint latency;
    logic   found;

    always #5 clk = ~clk;

    uart_receiver #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .divisor     (divisor),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    // Count status pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (overflow)    ovf_count++;
        if (frame_error) ferr_count++;
    end

    // Remember when the head-valid flag last rose.
    always @(posedge rx_valid) rise_time = $time;

    // Bound the whole run so a stuck design still ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one 8N1 frame; stop_low_bits > 0 holds the line low that many
    // bit times where the stop bit belongs, before a normal high stop bit.
    task automatic applyStimulus(input logic [7:0] value, input int bit_t, input int stop_low_bits);
        start_time = $time;
        uart_rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            uart_rx = value[i];
            #(bit_t);
        end
        if (stop_low_bits > 0) begin
            uart_rx = 1'b0;
            #(bit_t * stop_low_bits);
        end
        uart_rx = 1'b1;
        #(bit_t);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic popExpect(input string tag, input logic [7:0] expected);
        @(negedge clk);
        checkOutput({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        checkOutput({tag, "_data"}, {24'd0, rx_data}, {24'd0, expected});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        divisor  = 16'd917;
        reset    = 1'b1;
        idleCycles(3);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_frame_error", {31'd0, frame_error}, 32'd0);
        checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        idleCycles(5);

        // 0x53 at the full-rate divisor; head valid about 9.5 bits after the
        // start edge plus the synchronizer delay.
        ovf0 = ovf_count; ferr0 = ferr_count;
        applyStimulus(8'h53, 9168, 0);
        idleCycles(5);
        latency = rise_time - start_time;
        checkOutput("t029_data", {24'd0, rx_data}, 32'h53);
        checkOutput("t029_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("t029_latency_window", {31'd0, (latency >= 87096) && (latency <= 87300)}, 32'd1);
        checkOutput("t029_no_frame_error", ferr_count - ferr0, 32'd0);
        checkOutput("t029_no_overflow", ovf_count - ovf0, 32'd0);
        popExpect("t029_pop", 8'h53);
        idleCycles(2);
        checkOutput("t029_empty", {31'd0, rx_valid}, 32'd0);

        // 300 ns glitch on the idle line is rejected at the start midpoint.
        ferr0 = ferr_count;
        uart_rx = 1'b0;
        #300;
        uart_rx = 1'b1;
        idleCycles(1000);
        checkOutput("t032_no_push", {31'd0, rx_valid}, 32'd0);
        checkOutput("t032_no_error", ferr_count - ferr0, 32'd0);
        divisor = 16'(FAST_BIT / 10);
        applyStimulus(8'h5A, FAST_BIT, 0);
        idleCycles(4);
        popExpect("t032_next", 8'h5A);

        // Four bytes fill the queue, the fifth is dropped with one overflow.
        ovf0 = ovf_count; ferr0 = ferr_count;
        applyStimulus(8'h00, FAST_BIT, 0);
        applyStimulus(8'hFF, FAST_BIT, 0);
        applyStimulus(8'hA5, FAST_BIT, 0);
        applyStimulus(8'h3C, FAST_BIT, 0);
        applyStimulus(8'h11, FAST_BIT, 0);
        idleCycles(4);
        checkOutput("t030_overflow_once", ovf_count - ovf0, 32'd1);
        checkOutput("t030_no_frame_error", ferr_count - ferr0, 32'd0);
        popExpect("t030_pop0", 8'h00);
        popExpect("t030_pop1", 8'hFF);
        popExpect("t030_pop2", 8'hA5);
        popExpect("t030_pop3", 8'h3C);
        idleCycles(2);
        checkOutput("t030_drained", {31'd0, rx_valid}, 32'd0);

        // Stop bit held low for two bit times gives one frame error.
        ovf0 = ovf_count; ferr0 = ferr_count;
        applyStimulus(8'h55, FAST_BIT, 2);
        idleCycles(40);
        checkOutput("t031_frame_error_once", ferr_count - ferr0, 32'd1);
        checkOutput("t031_fifo_empty", {31'd0, rx_valid}, 32'd0);
        checkOutput("t031_no_overflow", ovf_count - ovf0, 32'd0);
        applyStimulus(8'h12, FAST_BIT, 0);
        idleCycles(4);
        popExpect("t031_next", 8'h12);

        // Reset from mid bit 4 of 0x6B until the stop bit abandons the frame.
        ferr0 = ferr_count;
        fork
            applyStimulus(8'h6B, FAST_BIT, 0);
            begin
                #(FAST_BIT * 5 + FAST_BIT / 2);
                reset = 1'b1;
                #(FAST_BIT * 4);
                reset = 1'b0;
            end
        join
        idleCycles(20);
        checkOutput("t033_no_partial", {31'd0, rx_valid}, 32'd0);
        checkOutput("t033_no_error", ferr_count - ferr0, 32'd0);
        applyStimulus(8'h6B, FAST_BIT, 0);
        idleCycles(4);
        popExpect("t033_next", 8'h6B);

        // Line held low across reset release is not a start bit.
        ferr0 = ferr_count;
        uart_rx = 1'b0;
        reset = 1'b1;
        idleCycles(3);
        reset = 1'b0;
        idleCycles(80);
        uart_rx = 1'b1;
        idleCycles(300);
        checkOutput("t026_low_release_no_push", {31'd0, rx_valid}, 32'd0);
        checkOutput("t026_low_release_no_error", ferr_count - ferr0, 32'd0);

        // Full queue with a pop in the very push cycle: no overflow, head moves.
        ovf0 = ovf_count;
        applyStimulus(8'h01, FAST_BIT, 0);
        applyStimulus(8'h02, FAST_BIT, 0);
        applyStimulus(8'h03, FAST_BIT, 0);
        applyStimulus(8'h04, FAST_BIT, 0);
        found = 1'b0;
        fork
            applyStimulus(8'h05, FAST_BIT, 0);
            begin
                for (int c = 0; c < 400 && !found; c++) begin
                    @(negedge clk);
                    if (dut.push) begin
                        found = 1'b1;
                        rx_ready = 1'b1;
                        @(negedge clk);
                        rx_ready = 1'b0;
                    end
                end
            end
        join
        checkOutput("t034_push_seen", {31'd0, found}, 32'd1);
        idleCycles(4);
        checkOutput("t034_no_overflow", ovf_count - ovf0, 32'd0);
        popExpect("t034_pop0", 8'h02);
        popExpect("t034_pop1", 8'h03);
        popExpect("t034_pop2", 8'h04);
        popExpect("t034_pop3", 8'h05);
        idleCycles(2);
        checkOutput("t034_drained", {31'd0, rx_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
